// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared FSM state encoding and default widths for mac_seq_ctrl
package mac_seq_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_BITS = 16;
  localparam int DEF_ID_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, BIAS, DATA, DRAIN} state_e;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: one-entry registered AXIS stage; in: clk, rst_n, in_valid, in_data, out_ready; out: load_ok, out_valid, out_data
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         load_ok,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    load_ok = !valid_q || out_ready;
    valid_d = load_ok ? in_valid : valid_q;
    data_d  = (load_ok && in_valid) ? in_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: joins weight/activation streams into MAC beats with optional bias beat, TLAST and TID
// Ports: ACLK/ARESETN (async active-low); CFG_START/LEN/NUM_OUT/BIAS_EN job config; BUSY, DONE status;
// SW/SA/SB_AXIS weight, activation, bias inputs; MO_AXIS registered output to staged_mac.
// MAC_SEQ_PERF_EN adds PERF_STALL_CNT and PERF_STARVE_CNT saturating counters.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_BITS   = DEF_LEN_BITS,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    CFG_START,
  input  logic [LEN_BITS-1:0]     CFG_LEN,
  input  logic [LEN_BITS-1:0]     CFG_NUM_OUT,
  input  logic                    CFG_BIAS_EN,
  output logic                    BUSY,
  output logic                    DONE,
  input  logic [DATA_WIDTH-1:0]   SW_AXIS_TDATA,
  input  logic                    SW_AXIS_TVALID,
  output logic                    SW_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]   SA_AXIS_TDATA,
  input  logic                    SA_AXIS_TVALID,
  output logic                    SA_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]   SB_AXIS_TDATA,
  input  logic                    SB_AXIS_TVALID,
  output logic                    SB_AXIS_TREADY,
  output logic [2*DATA_WIDTH-1:0] MO_AXIS_TDATA,
  output logic                    MO_AXIS_TUSER,
  output logic                    MO_AXIS_TLAST,
  output logic [ID_WIDTH-1:0]     MO_AXIS_TID,
  output logic                    MO_AXIS_TVALID,
  input  logic                    MO_AXIS_TREADY
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]             PERF_STALL_CNT,
  output logic [31:0]             PERF_STARVE_CNT
`endif
);
  localparam int PW = 2 * DATA_WIDTH + ID_WIDTH + 2;
  state_e                state_q, state_d;
  logic [LEN_BITS-1:0]   len_q, len_d, num_q, num_d, prod_q, prod_d, out_q, out_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic                  bias_en_q, bias_en_d, done_q, done_d;
  logic                  load_ok, bias_fire, data_fire, last_prod, last_out;
  logic [PW-1:0]         mo_in, mo_out;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    num_d     = num_q;
    bias_en_d = bias_en_q;
    prod_d    = prod_q;
    out_d     = out_q;
    tid_d     = tid_q;
    done_d    = 1'b0;
    bias_fire = state_q == BIAS && load_ok && SB_AXIS_TVALID;
    data_fire = state_q == DATA && load_ok && SW_AXIS_TVALID && SA_AXIS_TVALID;
    last_prod = prod_q == len_q - 1'b1;
    last_out  = out_q == num_q - 1'b1;
    case (state_q)
      IDLE: if (CFG_START) begin
        len_d     = CFG_LEN;
        num_d     = CFG_NUM_OUT;
        bias_en_d = CFG_BIAS_EN;
        prod_d    = '0;
        out_d     = '0;
        tid_d     = '0;
        state_d   = (CFG_LEN == '0 || CFG_NUM_OUT == '0) ? DRAIN : CFG_BIAS_EN ? BIAS : DATA;
      end
      BIAS: if (bias_fire) state_d = DATA;
      DATA: if (data_fire) begin
        prod_d = last_prod ? '0 : prod_q + 1'b1;
        if (last_prod && last_out) state_d = DRAIN;
        else if (last_prod) begin
          out_d   = out_q + 1'b1;
          tid_d   = tid_q + 1'b1;
          state_d = bias_en_q ? BIAS : DATA;
        end
      end
      DRAIN: if (!MO_AXIS_TVALID || MO_AXIS_TREADY) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    mo_in = {bias_fire, data_fire && last_prod, tid_q,
             bias_fire ? {{DATA_WIDTH{1'b0}}, SB_AXIS_TDATA} : {SW_AXIS_TDATA, SA_AXIS_TDATA}};
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      len_q     <= '0;
      num_q     <= '0;
      bias_en_q <= 1'b0;
      prod_q    <= '0;
      out_q     <= '0;
      tid_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      num_q     <= num_d;
      bias_en_q <= bias_en_d;
      prod_q    <= prod_d;
      out_q     <= out_d;
      tid_q     <= tid_d;
      done_q    <= done_d;
    end
  end
  axis_reg_slice #(.W(PW)) u_mo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .in_valid  (bias_fire || data_fire),
    .in_data   (mo_in),
    .load_ok   (load_ok),
    .out_valid (MO_AXIS_TVALID),
    .out_data  (mo_out),
    .out_ready (MO_AXIS_TREADY)
  );
  assign {MO_AXIS_TUSER, MO_AXIS_TLAST, MO_AXIS_TID, MO_AXIS_TDATA} = mo_out;
  assign BUSY           = state_q != IDLE;
  assign DONE           = done_q;
  assign SW_AXIS_TREADY = data_fire;
  assign SA_AXIS_TREADY = data_fire;
  assign SB_AXIS_TREADY = state_q == BIAS && load_ok;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d, starve_q, starve_d;
  logic        clr, stall, starve;
  always_comb begin
    clr      = state_q == IDLE && CFG_START;
    stall    = MO_AXIS_TVALID && !MO_AXIS_TREADY;
    starve   = load_ok && ((state_q == BIAS && !SB_AXIS_TVALID) ||
                           (state_q == DATA && !(SW_AXIS_TVALID && SA_AXIS_TVALID)));
    stall_d  = clr ? '0 : stall_q + {31'b0, stall && stall_q != '1};
    starve_d = clr ? '0 : starve_q + {31'b0, starve && starve_q != '1};
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end
  assign PERF_STALL_CNT  = stall_q;
  assign PERF_STARVE_CNT = starve_q;
`endif
endmodule
